// File: rtl/shared_ocm_mutex_client.sv
// rtl/shared_ocm_mutex_client.sv - Avalon-MM client that acquires and releases a shared hardware mutex
// Write-then-read-back acquire loop with back-off; ownership is proven by reading our own word back.
module shared_ocm_mutex_client #(
  parameter logic [15:0] OWNER_ID    = 16'h0001,
  parameter logic [15:0] LOCK_VALUE  = 16'h0001,
  parameter int unsigned RETRY_DELAY = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        lock_req,
  input  logic        unlock_req,
  output logic        granted,
  output logic        busy,
  output logic [7:0]  attempts,
  output logic        avm_address,
  output logic        avm_chipselect,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACQ_WR,
    S_ACQ_RD,
    S_BACKOFF,
    S_LOCKED,
    S_REL_WR
  } state_t;

  localparam logic [31:0] LOCK_WORD   = {OWNER_ID, LOCK_VALUE};
  localparam logic [31:0] UNLOCK_WORD = {OWNER_ID, 16'h0000};
  localparam logic [7:0]  RELOAD      = 8'(RETRY_DELAY - 1);

  state_t     state_q, state_d;
  logic [7:0] attempts_q, attempts_d;
  logic [7:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      attempts_q <= 8'd0;
      cnt_q      <= 8'd0;
    end else begin
      state_q    <= state_d;
      attempts_q <= attempts_d;
      cnt_q      <= cnt_d;
    end
  end

  // Outputs decode from state only, so they are stable across waitrequest stalls.
  always_comb begin
    state_d        = state_q;
    attempts_d     = attempts_q;
    cnt_d          = cnt_q;
    granted        = 1'b0;
    busy           = 1'b1;
    avm_address    = 1'b0;
    avm_chipselect = 1'b0;
    avm_read       = 1'b0;
    avm_write      = 1'b0;
    avm_writedata  = 32'h0;

    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (lock_req) begin
          state_d    = S_ACQ_WR;
          attempts_d = 8'd0;
        end
      end
      S_ACQ_WR: begin
        avm_chipselect = 1'b1;
        avm_write      = 1'b1;
        avm_writedata  = LOCK_WORD;
        if (!avm_waitrequest) begin
          if (attempts_q != 8'hFF) attempts_d = attempts_q + 8'd1;
          state_d = S_ACQ_RD;
        end
      end
      S_ACQ_RD: begin
        avm_chipselect = 1'b1;
        avm_read       = 1'b1;
        if (!avm_waitrequest) begin
          // A matching read-back wins the lock even if the caller has since withdrawn.
          if (avm_readdata == LOCK_WORD) begin
            state_d = S_LOCKED;
          end else if (lock_req) begin
            state_d = S_BACKOFF;
            cnt_d   = RELOAD;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_BACKOFF: begin
        if (cnt_q == 8'd0) begin
          state_d = lock_req ? S_ACQ_WR : S_IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_LOCKED: begin
        busy    = 1'b0;
        granted = 1'b1;
        if (unlock_req) state_d = S_REL_WR;
      end
      S_REL_WR: begin
        avm_chipselect = 1'b1;
        avm_write      = 1'b1;
        avm_writedata  = UNLOCK_WORD;
        if (!avm_waitrequest) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign attempts = attempts_q;

endmodule

// File: tb/tb_shared_ocm_mutex_client.sv
// tb/tb_shared_ocm_mutex_client.sv - scoreboard bench for shared_ocm_mutex_client
// Stimulus queues expected bus transfers; the negedge slave/monitor pops and compares them.
module tb_shared_ocm_mutex_client;

  localparam logic [31:0] LOCK_W   = 32'h00020001;
  localparam logic [31:0] UNLOCK_W = 32'h00020000;
  localparam logic [31:0] OTHER_W  = 32'h00030001;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        lock_req;
  logic        unlock_req;
  logic        granted;
  logic        busy;
  logic [7:0]  attempts;
  logic        avm_address;
  logic        avm_chipselect;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;

  shared_ocm_mutex_client #(
    .OWNER_ID   (16'h0002),
    .LOCK_VALUE (16'h0001),
    .RETRY_DELAY(4)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .lock_req       (lock_req),
    .unlock_req     (unlock_req),
    .granted        (granted),
    .busy           (busy),
    .attempts       (attempts),
    .avm_address    (avm_address),
    .avm_chipselect (avm_chipselect),
    .avm_read       (avm_read),
    .avm_write      (avm_write),
    .avm_writedata  (avm_writedata),
    .avm_readdata   (avm_readdata),
    .avm_waitrequest(avm_waitrequest)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_wr;
    logic [31:0] data;
  } xfer_t;

  xfer_t       exp_q[$];
  logic [31:0] resp_q[$];
  logic [31:0] default_rd = 32'h0;
  int          wr_stall   = 0;
  int          rd_stall   = 0;
  bit          sat_mode   = 0;
  int          errors     = 0;
  int          checks     = 0;
  int          gap        = 0;
  bit          prev_stall = 0;
  logic [35:0] prev_bus;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_w(input logic [31:0] d);
    exp_q.push_back('{is_wr: 1'b1, data: d});
  endtask

  task automatic expect_r();
    exp_q.push_back('{is_wr: 1'b0, data: 32'h0});
  endtask

  task automatic wait_grant(input int limit, output int n);
    n = 0;
    while (!granted && n < limit) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Slave model, protocol checker and scoreboard monitor.
  always @(negedge clk) begin
    xfer_t e;
    if (avm_write && wr_stall > 0) begin
      avm_waitrequest = 1'b1;
      wr_stall--;
    end else if (avm_read && rd_stall > 0) begin
      avm_waitrequest = 1'b1;
      rd_stall--;
    end else begin
      avm_waitrequest = 1'b0;
    end
    avm_readdata = (resp_q.size() > 0) ? resp_q[0] : default_rd;
    #1;
    check("rd_wr_exclusive", 32'(avm_read & avm_write), 32'h0);
    check("chipselect_or", 32'(avm_chipselect), 32'(avm_read | avm_write));
    check("address_zero", 32'(avm_address), 32'h0);
    if (prev_stall)
      check("stable_under_wait", 32'(prev_bus ^ {avm_chipselect, avm_read, avm_write, avm_address, avm_writedata}), 32'h0);
    if (avm_chipselect && avm_write && avm_writedata == LOCK_W) begin
      if (gap != 0) check("backoff_gap", 32'(gap), 32'd4);
    end
    if (busy && !avm_chipselect) gap++;
    else gap = 0;
    prev_stall = avm_chipselect && avm_waitrequest;
    prev_bus   = {avm_chipselect, avm_read, avm_write, avm_address, avm_writedata};
    if (avm_chipselect && !avm_waitrequest) begin
      if (sat_mode) begin
        if (avm_write) check("sat_write_data", avm_writedata, LOCK_W);
      end else if (exp_q.size() == 0) begin
        check("unexpected_transfer", {30'h0, avm_write, avm_read}, 32'h0);
      end else begin
        e = exp_q.pop_front();
        check("xfer_kind", 32'(avm_write), 32'(e.is_wr));
        if (e.is_wr) check("xfer_writedata", avm_writedata, e.data);
      end
      if (avm_read && resp_q.size() > 0) void'(resp_q.pop_front());
    end
  end

  task automatic release_lock();
    expect_w(UNLOCK_W);
    unlock_req = 1'b1;
    @(negedge clk);
    unlock_req = 1'b0;
    check("rel_granted_low", 32'(granted), 32'h0);
    check("rel_busy", 32'(busy), 32'h1);
    @(negedge clk);
    check("post_rel_busy", 32'(busy), 32'h0);
    check("post_rel_granted", 32'(granted), 32'h0);
  endtask

  initial begin
    int n;
    reset_n         = 1'b0;
    lock_req        = 1'b0;
    unlock_req      = 1'b0;
    avm_readdata    = 32'h0;
    avm_waitrequest = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_granted", 32'(granted), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_attempts", 32'(attempts), 32'h0);
    check("rst_cs", 32'(avm_chipselect), 32'h0);
    check("rst_writedata", avm_writedata, 32'h0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // unlock_req outside LOCKED does nothing
    unlock_req = 1'b1;
    @(negedge clk);
    unlock_req = 1'b0;
    @(negedge clk);
    check("idle_unlock_ignored", 32'(busy), 32'h0);

    // free mutex
    resp_q.push_back(LOCK_W);
    expect_w(LOCK_W); expect_r();
    lock_req = 1'b1;
    wait_grant(20, n);
    check("free_grant_latency", 32'(n), 32'd3);
    check("free_attempts", 32'(attempts), 32'd1);
    check("locked_busy", 32'(busy), 32'h0);
    lock_req = 1'b0;
    repeat (3) @(negedge clk);
    check("locked_holds", 32'(granted), 32'h1);
    release_lock();
    check("attempts_hold_idle", 32'(attempts), 32'd1);

    // contended by owner 3 twice
    resp_q.push_back(OTHER_W); resp_q.push_back(OTHER_W); resp_q.push_back(LOCK_W);
    repeat (3) begin expect_w(LOCK_W); expect_r(); end
    lock_req = 1'b1;
    wait_grant(60, n);
    check("contend_latency", 32'(n), 32'd15);
    check("contend_attempts", 32'(attempts), 32'd3);
    lock_req = 1'b0;
    release_lock();

    // waitrequest stalls: 3 on write, 2 on read
    wr_stall = 3; rd_stall = 2;
    resp_q.push_back(LOCK_W);
    expect_w(LOCK_W); expect_r();
    lock_req = 1'b1;
    wait_grant(30, n);
    check("stall_grant_latency", 32'(n), 32'd8);
    check("stall_attempts", 32'(attempts), 32'd1);
    lock_req = 1'b0;
    release_lock();

    // lock_req dropped in BACKOFF
    resp_q.push_back(OTHER_W);
    expect_w(LOCK_W); expect_r();
    lock_req = 1'b1;
    repeat (3) @(negedge clk);
    lock_req = 1'b0;
    repeat (8) @(negedge clk);
    check("backoff_drop_busy", 32'(busy), 32'h0);
    check("backoff_drop_granted", 32'(granted), 32'h0);
    check("backoff_drop_attempts", 32'(attempts), 32'd1);

    // lock_req dropped during ACQ_WR, read-back matches: still locked
    resp_q.push_back(LOCK_W);
    expect_w(LOCK_W); expect_r();
    lock_req = 1'b1;
    @(negedge clk);
    lock_req = 1'b0;
    wait_grant(10, n);
    check("drop_wr_grant_latency", 32'(n), 32'd2);
    release_lock();

    // lock_req dropped during ACQ_RD, read-back fails: straight to IDLE
    resp_q.push_back(OTHER_W);
    expect_w(LOCK_W); expect_r();
    lock_req = 1'b1;
    repeat (2) @(negedge clk);
    lock_req = 1'b0;
    @(negedge clk);
    check("drop_rd_fail_idle", 32'(busy), 32'h0);

    // reset while LOCKED: no release write
    resp_q.push_back(LOCK_W);
    expect_w(LOCK_W); expect_r();
    lock_req = 1'b1;
    wait_grant(20, n);
    check("pre_reset_grant", 32'(granted), 32'h1);
    lock_req = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_granted", 32'(granted), 32'h0);
    check("async_rst_attempts", 32'(attempts), 32'h0);
    check("async_rst_cs", 32'(avm_chipselect), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    check("post_rst_idle", 32'(busy), 32'h0);

    // permanently held mutex: attempts saturates
    sat_mode   = 1'b1;
    default_rd = OTHER_W;
    lock_req   = 1'b1;
    n = 0;
    while (attempts != 8'hFF && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("sat_reached", 32'(attempts), 32'hFF);
    repeat (60) @(negedge clk);
    check("sat_holds", 32'(attempts), 32'hFF);
    check("sat_not_granted", 32'(granted), 32'h0);
    lock_req = 1'b0;
    repeat (12) @(negedge clk);
    check("sat_idle", 32'(busy), 32'h0);
    check("sat_attempts_idle", 32'(attempts), 32'hFF);
    sat_mode   = 1'b0;
    default_rd = 32'h0;

    repeat (3) @(negedge clk);
    check("exp_q_drained", 32'(exp_q.size()), 32'h0);
    check("resp_q_drained", 32'(resp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
